// File: rtl/conv1_ofm_writer.sv
// conv1_ofm_writer: captures conv1 ofm vectors into a ping-pong buffer
// and drains them as LANES-wide words into the layer-1 OFM RAM.
// Ports: clk, rst (async, active-high); conv1_sample/conv1_finish/ofm
// from conv1; ram_we/ram_addr/ram_wdata to the RAM; ram_feedback pulse
// back to conv1; pixel_count, overflow (sticky), busy status.
module conv1_ofm_writer #(
   parameter int DSP_NO = 64,
   parameter int WIDTH  = 16,
   parameter int WOUT   = 128,
   parameter int LANES  = 4,
   parameter int ADDR_W = 18
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     conv1_sample,
   input  logic                     conv1_finish,
   input  logic [WIDTH-1:0]         ofm [0:DSP_NO-1],
   output logic                     ram_we,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [LANES*WIDTH-1:0]   ram_wdata,
   output logic                     ram_feedback,
   output logic [$clog2(WOUT*WOUT):0] pixel_count,
   output logic                     overflow,
   output logic                     busy
);

   localparam int GROUPS = DSP_NO / LANES;
   localparam int PIX    = WOUT * WOUT;
   localparam int PC_W   = $clog2(PIX) + 1;
   localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int CH_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [G_W-1:0]         g_q, g_d;
   logic                   wptr_q, wptr_d;
   logic                   rptr_q, rptr_d;
   logic [1:0]             full_q, full_d;
   logic [PC_W-1:0]        pix_q [0:1];
   logic [PC_W-1:0]        pix_d [0:1];
   logic [WIDTH-1:0]       obuf_q [0:1][0:DSP_NO-1];
   logic [WIDTH-1:0]       obuf_d [0:1][0:DSP_NO-1];
   logic [PC_W-1:0]        pc_q, pc_d;
   logic                   ovf_q, ovf_d;
   logic                   we_q, we_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [LANES*WIDTH-1:0] wdata_q, wdata_d;
   logic                   fb_q, fb_d;
   logic                   busy_q, busy_d;

   logic issue, last, rel, cap_try, free;

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      full_d  = full_q;
      pix_d   = pix_q;
      obuf_d  = obuf_q;
      pc_d    = pc_q;
      ovf_d   = ovf_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fb_d    = 1'b0;

      // The oldest occupied buffer is always the one at rptr.
      issue = (state_q != S_DONE) && full_q[rptr_q];
      last  = (g_q == G_W'(GROUPS - 1));
      rel   = issue && last;
      we_d  = issue;

      if (issue) begin
         addr_d = ADDR_W'(pix_q[rptr_q]) * ADDR_W'(GROUPS)
                + ADDR_W'(g_q);
         for (int j = 0; j < LANES; j++) begin
            wdata_d[j*WIDTH +: WIDTH] =
               obuf_q[rptr_q][CH_W'(int'(g_q) * LANES + j)];
         end
         if (last) begin
            g_d            = '0;
            full_d[rptr_q] = 1'b0;
            rptr_d         = ~rptr_q;
            state_d = full_q[~rptr_q] ? S_WRITE : S_IDLE;
         end else begin
            g_d     = g_q + G_W'(1);
            state_d = S_WRITE;
         end
      end else if (state_q == S_IDLE && conv1_finish &&
                   pc_q == PC_W'(PIX) && full_q == 2'b00) begin
         state_d = S_DONE;
         fb_d    = 1'b1;
      end

      // A buffer released on this edge can be refilled on the same edge.
      cap_try = conv1_sample && (pc_q < PC_W'(PIX)) &&
                (state_q != S_DONE);
      free    = !full_q[wptr_q] || (rel && rptr_q == wptr_q);
      if (cap_try) begin
         if (free) begin
            for (int i = 0; i < DSP_NO; i++) begin
               obuf_d[wptr_q][i] = ofm[i];
            end
            pix_d[wptr_q]  = pc_q;
            full_d[wptr_q] = 1'b1;
            wptr_d         = ~wptr_q;
            pc_d           = pc_q + PC_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end

      busy_d = (full_q != 2'b00) || (state_q == S_WRITE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         g_q     <= '0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         full_q  <= 2'b00;
         pc_q    <= '0;
         ovf_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         fb_q    <= 1'b0;
         busy_q  <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            pix_q[b] <= '0;
            for (int i = 0; i < DSP_NO; i++) begin
               obuf_q[b][i] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         pc_q    <= pc_d;
         ovf_q   <= ovf_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fb_q    <= fb_d;
         busy_q  <= busy_d;
         for (int b = 0; b < 2; b++) begin
            pix_q[b] <= pix_d[b];
            for (int i = 0; i < DSP_NO; i++) begin
               obuf_q[b][i] <= obuf_d[b][i];
            end
         end
      end
   end

   assign ram_we       = we_q;
   assign ram_addr     = addr_q;
   assign ram_wdata    = wdata_q;
   assign ram_feedback = fb_q;
   assign pixel_count  = pc_q;
   assign overflow     = ovf_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_conv1_ofm_writer.sv
// Directed testbench for conv1_ofm_writer, using an 8x8 layer so the
// full-layer scenario stays short.
module tb_conv1_ofm_writer;

   localparam int DSP_NO = 64;
   localparam int WIDTH  = 16;
   localparam int WOUT   = 8;
   localparam int LANES  = 4;
   localparam int ADDR_W = 10;
   localparam int PC_W   = $clog2(WOUT*WOUT) + 1;

   logic                   clk;
   logic                   rst;
   logic                   conv1_sample;
   logic                   conv1_finish;
   logic [WIDTH-1:0]       ofm [0:DSP_NO-1];
   logic                   ram_we;
   logic [ADDR_W-1:0]      ram_addr;
   logic [LANES*WIDTH-1:0] ram_wdata;
   logic                   ram_feedback;
   logic [PC_W-1:0]        pixel_count;
   logic                   overflow;
   logic                   busy;

   int n_assert = 0;
   int n_fail   = 0;

   conv1_ofm_writer #(
      .DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT),
      .LANES(LANES), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst),
      .conv1_sample(conv1_sample), .conv1_finish(conv1_finish),
      .ofm(ofm),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_feedback(ram_feedback), .pixel_count(pixel_count),
      .overflow(overflow), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      conv1_sample = 1'b0;
      conv1_finish = 1'b0;
      wait_n(2);
      rst = 1'b0;
   endtask

   task automatic send(input int vbase);
      for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'(vbase + i);
      conv1_sample = 1'b1;
      step();
      conv1_sample = 1'b0;
   endtask

   task automatic check_word(input int abase, input int vbase,
                             input int g);
      logic [63:0] w;
      w = '0;
      for (int j = 0; j < LANES; j++)
         w[j*16 +: 16] = 16'(vbase + g*4 + j);
      chk("we", 64'(ram_we), 64'd1);
      chk("addr", 64'(ram_addr), 64'(abase + g));
      chk("wdata", ram_wdata, w);
   endtask

   task automatic expect_pixel(input int abase, input int vbase,
                               input int gs);
      for (int g = gs; g < 16; g++) begin
         step();
         check_word(abase, vbase, g);
      end
   endtask

   task automatic gap_idle(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         chk("gap_we", 64'(ram_we), 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1;
      conv1_sample = 1'b0;
      conv1_finish = 1'b0;
      for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
      #1;
      chk("rst_we", 64'(ram_we), 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_wdata", ram_wdata, 64'd0);
      chk("rst_fb", 64'(ram_feedback), 64'd0);
      chk("rst_pc", 64'(pixel_count), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // 1: single pixel
      do_reset();
      send(0);
      chk("t1_pc", 64'(pixel_count), 64'd1);
      expect_pixel(0, 0, 0);
      chk("t1_w15", ram_wdata, 64'h003f_003e_003d_003c);
      chk("t1_busy_last", 64'(busy), 64'd1);
      step();
      chk("t1_we_off", 64'(ram_we), 64'd0);
      chk("t1_busy_off", 64'(busy), 64'd0);

      // 2: three pixels at the 28-cycle period
      do_reset();
      for (int p = 0; p < 3; p++) begin
         send(p*100);
         expect_pixel(p*16, p*100, 0);
         if (p < 2) gap_idle(11);
      end
      chk("t2_ovf", 64'(overflow), 64'd0);
      chk("t2_pc", 64'(pixel_count), 64'd3);

      // 3: three back-to-back samples, third dropped
      do_reset();
      for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'(i);
      conv1_sample = 1'b1;
      step();
      for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'(100 + i);
      step();
      check_word(0, 0, 0);
      for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'(200 + i);
      step();
      conv1_sample = 1'b0;
      check_word(0, 0, 1);
      chk("t3_ovf", 64'(overflow), 64'd1);
      chk("t3_pc", 64'(pixel_count), 64'd2);
      expect_pixel(0, 0, 2);
      expect_pixel(16, 100, 0);
      step();
      chk("t3_we_off", 64'(ram_we), 64'd0);
      chk("t3_ovf_sticky", 64'(overflow), 64'd1);
      chk("t3_pc_end", 64'(pixel_count), 64'd2);

      // 3b: capture on the edge that releases the full buffer
      do_reset();
      send(0);
      send(100);
      wait_n(14);
      for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'(300 + i);
      conv1_sample = 1'b1;
      step();
      conv1_sample = 1'b0;
      chk("t3b_addr15", 64'(ram_addr), 64'd15);
      chk("t3b_ovf", 64'(overflow), 64'd0);
      chk("t3b_pc", 64'(pixel_count), 64'd3);
      expect_pixel(16, 100, 0);
      expect_pixel(32, 300, 0);

      // 4: full layer, finish raised 2 cycles after the last sample
      do_reset();
      for (int p = 0; p < WOUT*WOUT - 1; p++) begin
         send(p*100);
         expect_pixel(p*16, p*100, 0);
         gap_idle(11);
      end
      send(6300);
      for (int g = 0; g < 16; g++) begin
         step();
         if (g == 1) conv1_finish = 1'b1;
         check_word(63*16, 6300, g);
         chk("t4_fb_early", 64'(ram_feedback), 64'd0);
      end
      chk("t4_last_addr", 64'(ram_addr), 64'd1023);
      step();
      chk("t4_fb_pulse", 64'(ram_feedback), 64'd1);
      step();
      chk("t4_fb_clear", 64'(ram_feedback), 64'd0);
      send(7000);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("t4_extra_we", 64'(ram_we), 64'd0);
         chk("t4_extra_fb", 64'(ram_feedback), 64'd0);
      end
      chk("t4_pc", 64'(pixel_count), 64'd64);
      chk("t4_ovf", 64'(overflow), 64'd0);

      // 5: reset during group 7 of pixel 5
      do_reset();
      for (int p = 0; p < 5; p++) begin
         send(p*100);
         wait_n(27);
      end
      send(500);
      wait_n(8);
      chk("t5_addr_g7", 64'(ram_addr), 64'd87);
      rst = 1'b1;
      #1;
      chk("t5_we", 64'(ram_we), 64'd0);
      chk("t5_addr", 64'(ram_addr), 64'd0);
      chk("t5_wdata", ram_wdata, 64'd0);
      chk("t5_fb", 64'(ram_feedback), 64'd0);
      chk("t5_pc", 64'(pixel_count), 64'd0);
      chk("t5_ovf", 64'(overflow), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      step();
      rst = 1'b0;
      wait_n(3);
      chk("t5_no_resume", 64'(ram_we), 64'd0);
      send(0);
      expect_pixel(0, 0, 0);
      chk("t5_pc_new", 64'(pixel_count), 64'd1);

      // 6: finish high on an incomplete layer
      do_reset();
      for (int p = 0; p < 11; p++) begin
         send(p*100);
         if (p == 10) conv1_finish = 1'b1;
         wait_n(27);
      end
      for (int k = 0; k < 30; k++) begin
         step();
         chk("t6_fb", 64'(ram_feedback), 64'd0);
      end
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_pc", 64'(pixel_count), 64'd11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/conv1_ofm_writer.md
Name: conv1_ofm_writer

Overview:
Receiving end of the conv1 output interface. On each conv1_sample pulse it captures the 64-channel ofm vector into a ping-pong buffer, then drains it as LANES-wide words into the layer-1 output feature-map RAM at pixel-major addresses. Once every pixel has been written and conv1_finish is high, it returns ram_feedback to conv1 so the next layer can start.

Parameters:
DSP_NO, 64, channels per ofm vector
WIDTH, 16, bits per channel value
WOUT, 128, output width/height; pixels per layer = WOUT**2
LANES, 4, channels packed per RAM word; DSP_NO must be a multiple of LANES
ADDR_W, 18, RAM address width; must satisfy 2**ADDR_W >= WOUT**2*DSP_NO/LANES

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
conv1_sample  in  1  one-cycle strobe: ofm is valid this cycle
conv1_finish  in  1  level from conv1: layer computation ended
ofm  in  WIDTH x [0:DSP_NO-1]  channel values, unpacked array
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  LANES*WIDTH  packed write data
ram_feedback  out  1  one-cycle pulse: all OFM data is in RAM
pixel_count  out  $clog2(WOUT**2)+1  number of pixels accepted so far
overflow  out  1  sticky flag: a sample was dropped because both buffers were full
busy  out  1  high while any buffer is occupied

Behaviour:
- Reset (async, rst=1): ram_we=0, ram_addr=0, ram_wdata=0, ram_feedback=0, pixel_count=0, overflow=0, busy=0. FSM goes to IDLE, buffer occupancy is cleared, and captured data is discarded. A reset mid-drain abandons the partial pixel and does not complete it.
- Capture:
  - Two buffers, each DSP_NO x WIDTH, with a write pointer and a read pointer.
  - On a clk edge with conv1_sample=1 and pixel_count<WOUT**2:
    - If a buffer is free, ofm is stored into buffer[wptr], wptr toggles, and pixel_count increments.
    - If both buffers are full, the sample is dropped, overflow is set, and pixel_count is unchanged.
  - Simultaneous release: if the drain issues the final group of a buffer on the same edge, that buffer counts as free for the capture.
  - Samples arriving when pixel_count==WOUT**2 are ignored silently: no write, no overflow.
- Drain FSM states:
  - IDLE: go to WRITE when occupancy>0.
  - WRITE: group counter g runs 0..DSP_NO/LANES-1. Each cycle drives ram_we=1, ram_addr=p*(DSP_NO/LANES)+g, where p is the pixel index of the buffer being drained. Lane j occupies ram_wdata[(j+1)*WIDTH-1 : j*WIDTH] and carries channel g*LANES+j.
  - After the last group, rptr toggles and the buffer is released. If the other buffer is full, stay in WRITE with g=0 and no idle cycle; otherwise go to IDLE.
  - DONE: entered from IDLE when conv1_finish=1, pixel_count==WOUT**2 and occupancy==0. ram_feedback=1 for exactly the entry cycle, then 0. The FSM stays in DONE and ignores all inputs until reset.
- Outputs are registered. The first ram_we of a pixel appears on the cycle after the capture edge. A pixel occupies DSP_NO/LANES=16 consecutive write cycles, which is less than the 28-cycle conv1 sample period.
- The pixel index p is stored with each buffer at capture time, equal to the pixel_count value before the increment. ram_addr arithmetic is unsigned, ADDR_W bits wide, with no wrap within a legal layer.
- busy = (occupancy>0) or (FSM==WRITE).
- If conv1_finish rises before the drain completes, ram_feedback is withheld until the last write is issued and the FSM has passed through IDLE.
- If conv1_finish is high but pixel_count<WOUT**2, ram_feedback is never asserted.

Test Plan:
1. Reset, then one sample with ofm[i]=i: 16 writes on consecutive cycles at addr 0..15. Word g=0 is {16'd3,16'd2,16'd1,16'd0} and word g=15 is {63,62,61,60}. pixel_count=1 and busy drops one cycle after the last write.
2. Samples every 28 cycles, 3 pixels with ofm[i]=p*100+i: addr ranges 0..15, 16..31, 32..47 with matching data, ram_we gaps of 12 cycles, overflow=0.
3. Three samples on consecutive cycles: the first two are buffered and written back-to-back (32 contiguous write cycles, addr 0..31). The third is dropped, overflow=1 and stays 1, pixel_count=2.
4. Full layer: 16384 samples at a 28-cycle period, with conv1_finish raised 2 cycles after the last sample. The last write is at addr 262143, and ram_feedback pulses once after it; a 16385th sample causes no write.
5. Reset asserted during group 7 of pixel 5: all outputs are 0 immediately. After release, a new sample writes addr 0..15 and pixel_count=1.
6. conv1_finish held high after pixel 100: ram_feedback is never asserted, and busy falls after the last write.
